// File: rtl/lc_tx_pkg.sv
// Shared types for the life-cycle enable receiver: the multi-bit lc_tx_e encoding,
// its validity check and the alert handshake state encoding.
package lc_tx_pkg;

   typedef enum logic [3:0] {
      On  = 4'hA,
      Off = 4'h5
   } lc_tx_e;

   localparam logic [3:0] LcOn  = 4'hA;
   localparam logic [3:0] LcOff = 4'h5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_LOW = 2'd2
   } lc_rx_alert_state_e;

   function automatic logic lc_tx_valid(input logic [3:0] i_val);
      return (i_val == LcOn) || (i_val == LcOff);
   endfunction

endpackage

// File: rtl/lc_tx_filter.sv
// Synchronizer chain plus stability filter: a value must be seen unchanged on the
// synchronized side long enough before it becomes the accepted value.
module lc_tx_filter #(
   parameter int         SyncStages   = 2,
   parameter int         FilterCycles = 4,
   parameter logic [3:0] ResetVal     = 4'h5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] i_d,
   output logic [3:0] o_acc,
   output logic       o_load,
   output logic [3:0] o_load_val
);

   localparam int CntW = $clog2(FilterCycles) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

   logic [3:0]      r_sync [SyncStages];
   logic [3:0]      r_cand;
   logic [CntW-1:0] r_cnt;
   logic [3:0]      r_acc;
   logic [3:0]      w_sync;
   logic            w_stable;
   logic            w_load;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < SyncStages; i++) r_sync[i] <= ResetVal;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < SyncStages; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_sync   = r_sync[SyncStages-1];
   assign w_stable = (w_sync == r_cand);
   // A load is reported only when the accepted value actually changes.
   assign w_load   = w_stable && (r_cnt == CntMax) && (r_cand != r_acc);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cand <= ResetVal;
         r_cnt  <= '0;
         r_acc  <= ResetVal;
      end else if (!w_stable) begin
         r_cand <= w_sync;
         r_cnt  <= '0;
      end else begin
         if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;
         if (w_load) r_acc <= r_cand;
      end
   end

   assign o_acc      = r_acc;
   assign o_load     = w_load;
   assign o_load_val = r_cand;

endmodule

// File: rtl/lc_tx_receiver.sv
// Consumer side of an lc_tx_e broadcast: filtered fail-safe decode, sticky error, and
// (when LC_TX_RX_ALERT_EN is defined) a four-phase alert request toward the alert handler.
module lc_tx_receiver
   import lc_tx_pkg::*;
#(
   parameter int SyncStages   = 2,
   parameter int FilterCycles = 4,
   parameter bit ResetValueOn = 1'b0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [3:0]         lc_en_i,
   output logic [3:0]         lc_en_o,
   output logic               en_o,
   output logic               err_o,
   input  logic               err_clr_i,
   output logic               alert_req_o,
   input  logic               alert_ack_i,
   output lc_rx_alert_state_e alert_state_o
);

   logic [3:0] w_acc;
   logic [3:0] w_load_val;
   logic       w_load;
   logic       w_err_set;
   logic       w_err_clr;
   logic       r_err;

   lc_tx_filter #(
      .SyncStages  (SyncStages),
      .FilterCycles(FilterCycles),
      .ResetVal    (ResetValueOn ? LcOn : LcOff)
   ) u_filter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_d       (lc_en_i),
      .o_acc     (w_acc),
      .o_load    (w_load),
      .o_load_val(w_load_val)
   );

   // Only the exact On code enables; every other code maps to Off.
   assign lc_en_o = (w_acc == LcOn) ? LcOn : LcOff;
   assign en_o    = (w_acc == LcOn);

   assign w_err_set = w_load && !lc_tx_valid(w_load_val);
   assign w_err_clr = err_clr_i && lc_tx_valid(w_acc);

   always_ff @(posedge clk_i) begin
      if (!rst_ni)        r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
   end

   assign err_o = r_err;

`ifdef LC_TX_RX_ALERT_EN
   // Four-phase handshake: req rises and holds until ack is seen high; req then drops
   // and a new request is not raised until ack has returned low.
   lc_rx_alert_state_e r_state;
   lc_rx_alert_state_e w_state_next;
   logic               r_pend;
   logic               w_pend_next;
   logic               r_err_evt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_pend    <= 1'b0;
         r_err_evt <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pend    <= w_pend_next;
         r_err_evt <= w_err_set;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pend_next  = r_pend;
      case (r_state)
         IDLE: begin
            if (r_err_evt || r_pend) begin
               w_state_next = REQ;
               w_pend_next  = 1'b0;
            end
         end
         REQ: begin
            if (alert_ack_i) w_state_next = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (r_err_evt)    w_pend_next  = 1'b1;
            if (!alert_ack_i) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign alert_req_o   = (r_state == REQ);
   assign alert_state_o = r_state;
`else
   logic w_unused_ack;
   assign w_unused_ack  = alert_ack_i;
   assign alert_req_o   = 1'b0;
   assign alert_state_o = IDLE;
`endif

endmodule
